const_to_note: RTL and testbench
================================

// Module: const_to_note
// PURPOSE
//  Inverse of the note->phase-increment constant map. Takes a 24-bit oscillator phase-increment
//  constant and returns the nearest note index (0..143) by iterative octave normalisation then
//  semitone decision. Used by pitch-bend/glide readback and the patch editor to display the
//  nearest note for arbitrary oscillator constants. Sits beside the note->constant map in synth_engine.
// PARAMETERS
//  CW        24   width of input constant
//  NW        8    width of note index output
//  NOTE_MAX  143  highest note index (12 octaves x 12 semitones)
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-high reset
//  in_valid   in   1   constant request valid
//  in_ready   out  1   block idle, request accepted when in_valid & in_ready
//  constant   in   24  phase-increment constant, sampled on accept
//  out_valid  out  1   result valid, held until out_ready
//  out_ready  in   1   consumer accepts result
//  note       out  8   nearest note index, 0..NOTE_MAX
//  under      out  1   constant below note 0 window (note forced 0)
//  over       out  1   constant above note 143 window (note forced 143)
//  resid      out  16  signed mantissa residual (see CONFIGURATION)
// BEHAVIOUR
//  Tables (package): SEMI_TBL[0..11]={2608,2763,2927,3101,3286,3481,3688,3908,4140,4386,4647,4923};
//   BOUND[0..11]={2534,2684,2844,3013,3192,3382,3583,3796,4022,4261,4515,4783} (geometric midpoints,
//   BOUND[0]=WIN_LO); WIN_HI=5068=2*WIN_LO. Nominal C(12o+s)=SEMI_TBL[s]<<o.
//  Reset: state IDLE; in_ready=1, out_valid=0, note=0, under=0, over=0, resid=0.
//  FSM IDLE -> OCT -> SEMI -> DONE -> IDLE.
//   IDLE: in_ready=1; on accept latch k=constant, clear o/s/flags, go OCT.
//   OCT: 12 cycles, step i=0..11: if k >= (WIN_LO<<i) then o<=i. Always runs 12 steps (fixed latency).
//   SEMI: 11 cycles, step j=1..11: if k >= (BOUND[j]<<o) then s<=j.
//   DONE: one cycle: note<=12*o+s; under<=(k<WIN_LO); over<=(k>=WIN_LO<<12 = 10,379,264);
//    under forces note=0,s=0; over forces note=NOTE_MAX; out_valid<=1.
//  Latency: accept at cycle 0 -> out_valid high at cycle 25; fixed, independent of data.
//  out_valid held, outputs stable, in_ready=0 until out_ready; handshake cycle returns IDLE,
//   in_ready=1 next cycle (no back-to-back accept in handshake cycle).
//  Comparisons unsigned, 24-bit operands; shifted bounds computed 25-bit, no truncation.
//  Bounds inclusive: k == BOUND[j]<<o selects semitone j.
//  reset mid-operation: abort, return to reset values next cycle; in-flight request dropped.
//  in_valid while busy: ignored (in_ready=0); constant not re-sampled.
// CONFIGURATION
//  FINE_CENTS_EN defined: DONE computes resid = signed((k>>o) - SEMI_TBL[s]) in 16 bits
//   (mantissa domain, range about -75..+145); under/over force resid=0. Extra 1 cycle none (same DONE).
//  FINE_CENTS_EN undefined: resid port present, driven constant 0; no subtractor synthesised.
// STRUCTURE
//  Package synth_pitch_pkg: SEMI_TBL, BOUND, WIN_LO, WIN_HI, NOTE_MAX, state enum typedef.
//  Sub-module bound_cmp: combinational (k, base, shift) -> (k >= base<<shift); one instance
//   shared by OCT and SEMI phases (base mux WIN_LO/BOUND[j]).
//  Remainder: FSM, step counter (4 bits), o/s registers, output regs.
// TESTING
//  k=3481 -> note=5, under=0, over=0, out_valid exactly 25 cycles after accept.
//  k=55,696 (3481<<4) -> note=53; k=5,341,184 (2608<<11) -> note=132.
//  k=2684 -> note=1; k=2683 -> note=0 (inclusive bound); k=100 -> note=0, under=1.
//  k=16,777,215 -> note=143, over=1; k=10,379,263 -> note=143, over=0.
//  out_ready low 10 cycles after result -> outputs stable, in_ready=0, new in_valid ignored.
//  reset asserted during SEMI -> next cycle in_ready=1, out_valid=0; with FINE_CENTS_EN k=3500 -> note=5, resid=+19 (0 without).

Source files
------------

// File: rtl/synth_pitch_pkg.sv
// rtl/synth_pitch_pkg.sv - shared tables, constants and state type for the constant->note inverse map
//
// Contents:
//   CW, NW       widths of the oscillator constant and of the note index
//   NOTE_MAX     highest note index (12 octaves x 12 semitones - 1)
//   WIN_LO       lower edge of the octave-0 mantissa window (also BOUND[0])
//   WIN_HI       upper edge of the mantissa window, 2*WIN_LO
//   OVER_TH      WIN_LO<<12, first constant above the note-143 window
//   semi_val()   SEMI_TBL: nominal octave-0 constant of each semitone
//   bound_val()  BOUND: geometric midpoints between neighbouring semitones
//   state_t      FSM state encoding
package synth_pitch_pkg;

    localparam int CW = 24;
    localparam int NW = 8;

    localparam logic [NW-1:0] NOTE_MAX = 8'd143;
    localparam logic [12:0]   WIN_LO   = 13'd2534;
    localparam logic [12:0]   WIN_HI   = 13'd5068;
    localparam logic [CW-1:0] OVER_TH  = 24'd10379264;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OCT  = 2'd1,
        ST_SEMI = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic [12:0] semi_val(input logic [3:0] idx);
        logic [12:0] v;
        case (idx)
            4'd0:    v = 13'd2608;
            4'd1:    v = 13'd2763;
            4'd2:    v = 13'd2927;
            4'd3:    v = 13'd3101;
            4'd4:    v = 13'd3286;
            4'd5:    v = 13'd3481;
            4'd6:    v = 13'd3688;
            4'd7:    v = 13'd3908;
            4'd8:    v = 13'd4140;
            4'd9:    v = 13'd4386;
            4'd10:   v = 13'd4647;
            4'd11:   v = 13'd4923;
            default: v = 13'd0;
        endcase
        return v;
    endfunction

    function automatic logic [12:0] bound_val(input logic [3:0] idx);
        logic [12:0] v;
        case (idx)
            4'd0:    v = WIN_LO;
            4'd1:    v = 13'd2684;
            4'd2:    v = 13'd2844;
            4'd3:    v = 13'd3013;
            4'd4:    v = 13'd3192;
            4'd5:    v = 13'd3382;
            4'd6:    v = 13'd3583;
            4'd7:    v = 13'd3796;
            4'd8:    v = 13'd4022;
            4'd9:    v = 13'd4261;
            4'd10:   v = 13'd4515;
            4'd11:   v = 13'd4783;
            default: v = 13'd0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/bound_cmp.sv
// rtl/bound_cmp.sv - unsigned compare of a constant against a shifted threshold
//
// Ports:
//   k_i      in  24  constant under test
//   base_i   in  13  unshifted threshold (WIN_LO or a semitone bound)
//   shift_i  in  4   left shift applied to base_i (octave)
//   ge_o     out 1   k_i >= (base_i << shift_i)
module bound_cmp
    import synth_pitch_pkg::*;
(
    input  logic [CW-1:0] k_i,
    input  logic [12:0]   base_i,
    input  logic [3:0]    shift_i,
    output logic          ge_o
);

    // One bit of headroom so a shifted threshold never wraps into a small value.
    logic [CW:0] shifted;

    assign shifted = {12'd0, base_i} << shift_i;
    assign ge_o    = {1'b0, k_i} >= shifted;

endmodule

// File: rtl/const_to_note.sv
// rtl/const_to_note.sv - nearest note index for a 24-bit oscillator phase-increment constant
//
// Build option: FINE_CENTS_EN - when defined, resid carries the signed mantissa
// residual (k>>o) - SEMI_TBL[s]; otherwise resid is tied to zero.
//
// Ports:
//   clk        in  1   system clock
//   reset      in  1   synchronous active-high reset
//   in_valid   in  1   constant request valid
//   in_ready   out 1   idle; request taken when in_valid & in_ready
//   constant   in  24  phase-increment constant, sampled on accept
//   out_valid  out 1   result valid, held until out_ready
//   out_ready  in  1   consumer accepts result
//   note       out 8   nearest note index 0..NOTE_MAX
//   under      out 1   constant below note-0 window (note forced 0)
//   over       out 1   constant above note-143 window (note forced NOTE_MAX)
//   resid      out 16  signed mantissa residual
module const_to_note
    import synth_pitch_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [CW-1:0] constant,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NW-1:0] note,
    output logic          under,
    output logic          over,
    output logic [15:0]   resid
);

    state_t        state_q, state_d;
    logic [3:0]    step_q, step_d;
    logic [CW-1:0] k_q, k_d;
    logic [3:0]    o_q, o_d;
    logic [3:0]    s_q, s_d;
    logic [NW-1:0] note_q, note_d;
    logic          under_q, under_d;
    logic          over_q, over_d;
    logic          out_valid_q, out_valid_d;

    logic [12:0]   cmp_base;
    logic [3:0]    cmp_shift;
    logic          cmp_ge;
    logic          under_w;
    logic          over_w;
    logic [NW-1:0] note_w;

    // Single comparator time-shared between the octave and semitone searches.
    always_comb begin
        cmp_base  = WIN_LO;
        cmp_shift = step_q;
        if (state_q == ST_SEMI) begin
            cmp_base  = bound_val(step_q);
            cmp_shift = o_q;
        end
    end

    bound_cmp u_bound_cmp (
        .k_i     (k_q),
        .base_i  (cmp_base),
        .shift_i (cmp_shift),
        .ge_o    (cmp_ge)
    );

    assign under_w = k_q < {11'd0, WIN_LO};
    assign over_w  = k_q >= OVER_TH;
    // 12*o + s as shift-and-add: 8*o + 4*o + s.
    assign note_w  = {1'b0, o_q, 3'b000} + {2'b00, o_q, 2'b00} + {4'b0000, s_q};

`ifdef FINE_CENTS_EN
    logic [15:0]   resid_q, resid_d;
    logic [CW-1:0] mant_w;

    assign mant_w = k_q >> o_q;
`endif

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        k_d         = k_q;
        o_d         = o_q;
        s_d         = s_q;
        note_d      = note_q;
        under_d     = under_q;
        over_d      = over_q;
        out_valid_d = out_valid_q;
`ifdef FINE_CENTS_EN
        resid_d     = resid_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    k_d     = constant;
                    o_d     = 4'd0;
                    s_d     = 4'd0;
                    step_d  = 4'd0;
                    note_d  = '0;
                    under_d = 1'b0;
                    over_d  = 1'b0;
`ifdef FINE_CENTS_EN
                    resid_d = '0;
`endif
                    state_d = ST_OCT;
                end
            end
            ST_OCT: begin
                // Thresholds rise with i, so the last hit is the octave.
                if (cmp_ge) begin
                    o_d = step_q;
                end
                if (step_q == 4'd11) begin
                    step_d  = 4'd1;
                    state_d = ST_SEMI;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            ST_SEMI: begin
                if (cmp_ge) begin
                    s_d = step_q;
                end
                if (step_q == 4'd11) begin
                    state_d = ST_DONE;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            ST_DONE: begin
                // First DONE cycle registers the result; later cycles wait for the consumer.
                if (!out_valid_q) begin
                    under_d     = under_w;
                    over_d      = over_w;
                    out_valid_d = 1'b1;
                    if (under_w) begin
                        note_d = '0;
                        s_d    = 4'd0;
                    end else if (over_w) begin
                        note_d = NOTE_MAX;
                    end else begin
                        note_d = note_w;
                    end
`ifdef FINE_CENTS_EN
                    if (under_w || over_w) begin
                        resid_d = '0;
                    end else begin
                        resid_d = 16'(mant_w - {11'd0, semi_val(s_q)});
                    end
`endif
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            step_q      <= 4'd0;
            k_q         <= '0;
            o_q         <= 4'd0;
            s_q         <= 4'd0;
            note_q      <= '0;
            under_q     <= 1'b0;
            over_q      <= 1'b0;
            out_valid_q <= 1'b0;
`ifdef FINE_CENTS_EN
            resid_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            k_q         <= k_d;
            o_q         <= o_d;
            s_q         <= s_d;
            note_q      <= note_d;
            under_q     <= under_d;
            over_q      <= over_d;
            out_valid_q <= out_valid_d;
`ifdef FINE_CENTS_EN
            resid_q     <= resid_d;
`endif
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = out_valid_q;
    assign note      = note_q;
    assign under     = under_q;
    assign over      = over_q;
`ifdef FINE_CENTS_EN
    assign resid     = resid_q;
`else
    assign resid     = '0;
`endif

endmodule

// File: tb/tb_const_to_note.sv
// tb/tb_const_to_note.sv - self-checking bench for const_to_note
module tb_const_to_note;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] constant;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  note;
    logic        under;
    logic        over;
    logic [15:0] resid;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    typedef struct {
        logic [7:0]  note;
        logic        under;
        logic        over;
        logic [15:0] resid;
    } exp_t;

    exp_t sb_q[$];

    int bnd[12]  = '{2534, 2684, 2844, 3013, 3192, 3382, 3583, 3796, 4022, 4261, 4515, 4783};
    int semi[12] = '{2608, 2763, 2927, 3101, 3286, 3481, 3688, 3908, 4140, 4386, 4647, 4923};

    const_to_note dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .constant  (constant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .note      (note),
        .under     (under),
        .over      (over),
        .resid     (resid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: scan every note window and keep the highest one whose lower edge is <= k.
    function automatic exp_t model(input logic [23:0] k);
        exp_t e;
        int   best;
        best = -1;
        for (int n = 0; n < 144; n++) begin
            if (longint'(k) >= (longint'(bnd[n % 12]) << (n / 12))) best = n;
        end
        e.under = (best < 0);
        e.over  = (k >= 24'd10379264);
        e.resid = 16'd0;
        if (e.under)     e.note = 8'd0;
        else if (e.over) e.note = 8'd143;
        else             e.note = 8'(best);
`ifdef FINE_CENTS_EN
        if (!e.under && !e.over) e.resid = 16'((int'(k) >> (best / 12)) - semi[best % 12]);
`endif
        return e;
    endfunction

    // Scoreboard: pop one expectation per output handshake.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            exp_t e;
            chk_cnt++;
            if (sb_q.size() == 0) begin
                $display("FAIL sb_unexpected: got result note=%0d, expected none", note);
            end else begin
                pass_cnt++;
                e = sb_q.pop_front();
                chk_cnt++;
                if (note !== e.note) $display("FAIL sb_note: got %0d expected %0d", note, e.note);
                else pass_cnt++;
                chk_cnt++;
                if (under !== e.under) $display("FAIL sb_under: got %0b expected %0b", under, e.under);
                else pass_cnt++;
                chk_cnt++;
                if (over !== e.over) $display("FAIL sb_over: got %0b expected %0b", over, e.over);
                else pass_cnt++;
                chk_cnt++;
                if (resid !== e.resid) $display("FAIL sb_resid: got %0d expected %0d", $signed(resid), $signed(e.resid));
                else pass_cnt++;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    // All stimulus tasks start and end at posedge + #1.
    task automatic accept(input logic [23:0] k);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1;
            w++;
        end
        chk_cnt++;
        if (in_ready !== 1'b1) $display("FAIL accept_ready: got %0b expected 1", in_ready);
        else pass_cnt++;
        in_valid = 1'b1;
        constant = k;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Returns cycles from accept (accept cycle = 0) to first cycle with out_valid high.
    task automatic wait_result(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 60);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk_cnt++; if (in_ready !== 1'b1)  $display("FAIL reset_in_ready: got %0b expected 1", in_ready);   else pass_cnt++;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %0b expected 0", out_valid); else pass_cnt++;
        chk_cnt++; if (note !== 8'd0)      $display("FAIL reset_note: got %0d expected 0", note);           else pass_cnt++;
        chk_cnt++; if (under !== 1'b0)     $display("FAIL reset_under: got %0b expected 0", under);         else pass_cnt++;
        chk_cnt++; if (over !== 1'b0)      $display("FAIL reset_over: got %0b expected 0", over);           else pass_cnt++;
        chk_cnt++; if (resid !== 16'd0)    $display("FAIL reset_resid: got %0d expected 0", resid);         else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_latency;
        int   lat;
        exp_t e;
        e.note = 8'd5; e.under = 1'b0; e.over = 1'b0;
`ifdef FINE_CENTS_EN
        e.resid = 16'd0;
`else
        e.resid = 16'd0;
`endif
        sb_q.push_back(e);
        accept(24'd3481);
        wait_result(lat);
        chk_cnt++;
        if (lat !== 25) $display("FAIL latency: got %0d cycles expected 25", lat);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_vectors;
        logic [23:0] ks[13] = '{24'd3481, 24'd55696, 24'd5341184, 24'd2684, 24'd2683, 24'd100,
                                24'd16777215, 24'd10379263, 24'd3500, 24'd0, 24'd2534,
                                24'd2533, 24'd10379264};
        logic [7:0]  ns[13] = '{8'd5, 8'd53, 8'd132, 8'd1, 8'd0, 8'd0, 8'd143, 8'd143, 8'd5,
                                8'd0, 8'd0, 8'd0, 8'd143};
        logic        us[13] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 0};
        logic        os[13] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 13; i++) begin
            int   lat;
            exp_t e;
            e.note  = ns[i];
            e.under = us[i];
            e.over  = os[i];
            e.resid = 16'd0;
`ifdef FINE_CENTS_EN
            if (ks[i] == 24'd3500) e.resid = 16'd19;
            else                   e.resid = model(ks[i]).resid;
`endif
            sb_q.push_back(e);
            accept(ks[i]);
            wait_result(lat);
            chk_cnt++;
            if (lat !== 25) $display("FAIL vec_latency k=%0d: got %0d expected 25", ks[i], lat);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_hold;
        int   lat;
        bit   seen;
        exp_t e;
        out_ready = 1'b0;
        e.note = 8'd53; e.under = 1'b0; e.over = 1'b0; e.resid = model(24'd55696).resid;
        sb_q.push_back(e);
        accept(24'd55696);
        wait_result(lat);
        chk_cnt++;
        if (lat !== 25) $display("FAIL hold_latency: got %0d expected 25", lat);
        else pass_cnt++;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1;
            constant = 24'd3481 + 24'(i);
            @(negedge clk);
            chk_cnt++; if (out_valid !== 1'b1) $display("FAIL hold_valid: got %0b expected 1", out_valid); else pass_cnt++;
            chk_cnt++; if (note !== 8'd53)     $display("FAIL hold_note: got %0d expected 53", note);     else pass_cnt++;
            chk_cnt++; if (in_ready !== 1'b0)  $display("FAIL hold_in_ready: got %0b expected 0", in_ready); else pass_cnt++;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk_cnt++; if (in_ready !== 1'b1)  $display("FAIL release_in_ready: got %0b expected 1", in_ready);   else pass_cnt++;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL release_out_valid: got %0b expected 0", out_valid); else pass_cnt++;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk_cnt++;
        if (seen !== 1'b0) $display("FAIL hold_ignored_req: got a result, expected none");
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        bit seen;
        accept(24'd3481);
        repeat (14) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk_cnt++; if (in_ready !== 1'b1)  $display("FAIL midrst_in_ready: got %0b expected 1", in_ready);   else pass_cnt++;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL midrst_out_valid: got %0b expected 0", out_valid); else pass_cnt++;
        chk_cnt++; if (note !== 8'd0)      $display("FAIL midrst_note: got %0d expected 0", note);           else pass_cnt++;
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        chk_cnt++;
        if (seen !== 1'b0) $display("FAIL midrst_dropped: got a result, expected none");
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back;
        logic [23:0] ks[3] = '{24'd2608, 24'd9795584, 24'd40544};
        for (int i = 0; i < 3; i++) begin
            int lat;
            sb_q.push_back(model(ks[i]));
            accept(ks[i]);
            wait_result(lat);
            chk_cnt++; if (lat !== 25)        $display("FAIL b2b_latency: got %0d expected 25", lat);       else pass_cnt++;
            chk_cnt++; if (in_ready !== 1'b0) $display("FAIL b2b_hs_ready: got %0b expected 0", in_ready);  else pass_cnt++;
            @(posedge clk); #1;
            chk_cnt++; if (in_ready !== 1'b1) $display("FAIL b2b_next_ready: got %0b expected 1", in_ready); else pass_cnt++;
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 8; i++) begin
            int          lat;
            logic [23:0] k;
            k = 24'($urandom) >> $urandom_range(0, 12);
            sb_q.push_back(model(k));
            accept(k);
            wait_result(lat);
            chk_cnt++;
            if (lat !== 25) $display("FAIL rand_latency k=%0d: got %0d expected 25", k, lat);
            else pass_cnt++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        constant  = 24'd0;
        out_ready = 1'b1;
        test_reset;
        test_latency;
        test_vectors;
        test_hold;
        test_reset_mid;
        test_back_to_back;
        test_random;
        chk_cnt++;
        if (sb_q.size() != 0) $display("FAIL sb_leftover: got %0d pending expected 0", sb_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
